// File: rtl/gmii_tx_monitor.sv
// Passive GMII/MII transmit-path checker: validates preamble/SFD, FCS, length, IFG and tx_er
// per frame and publishes a registered per-frame status plus running frame/error counters.
module gmii_tx_monitor #(
    parameter int unsigned MIN_FRAME_LENGTH = 64,
    parameter int unsigned MAX_FRAME_LENGTH = 1518
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  gmii_txd,
    input  logic        gmii_tx_en,
    input  logic        gmii_tx_er,
    input  logic        clk_enable,
    input  logic        mii_select,
    input  logic [7:0]  ifg_delay,
    output logic        frame_valid,
    output logic [15:0] frame_len,
    output logic        err_preamble,
    output logic        err_fcs,
    output logic        err_runt,
    output logic        err_giant,
    output logic        err_tx_er,
    output logic        err_ifg,
    output logic [7:0]  last_ifg,
    output logic [31:0] frame_count,
    output logic [31:0] bad_count
);

    localparam logic [15:0] MinLen  = 16'(MIN_FRAME_LENGTH);
    localparam logic [15:0] MaxLen  = 16'(MAX_FRAME_LENGTH);
    localparam logic [31:0] CrcInit = 32'hFFFF_FFFF;
    localparam logic [31:0] Residue = 32'hDEBB_20E3;

    typedef enum logic [1:0] {StIdle, StPreamble, StData, StDrain} state_e;

    state_e      state_q, state_d, cur_state;
    logic [3:0]  pre_cnt_q, pre_cnt_d, pre_cnt_cur;
    logic [31:0] crc_q, crc_d, crc_cur;
    logic [15:0] len_q, len_d, len_cur;
    logic        err_pre_q, err_pre_d, err_pre_cur;
    logic        txer_q, txer_d, txer_cur;
    logic        nib_phase_q, idle_phase_q, first_frame_q, ifg_err_pend_q;
    logic [3:0]  nib_lo_q;
    logic [7:0]  ifg_cnt_q, ifg_pend_q;
    logic        byte_valid, sof, eof;
    logic [7:0]  byte_data;
    logic        end_pre, end_fcs, end_runt, end_giant, end_bad;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    // MII assembles low nibble first; a byte completes on the second enabled nibble.
    always_comb begin
        byte_valid = 1'b0;
        byte_data  = gmii_txd;
        if (clk_enable && gmii_tx_en) begin
            if (!mii_select) begin
                byte_valid = 1'b1;
            end else if (nib_phase_q) begin
                byte_valid = 1'b1;
                byte_data  = {gmii_txd[3:0], nib_lo_q};
            end
        end
    end

    assign sof = clk_enable && gmii_tx_en && (state_q == StIdle);
    assign eof = clk_enable && !gmii_tx_en && (state_q != StIdle);

    // On the start-of-frame cycle the per-frame state is taken as freshly cleared, so a GMII
    // first byte is already checked as preamble.
    assign cur_state   = sof ? StPreamble : state_q;
    assign pre_cnt_cur = sof ? 4'd0 : pre_cnt_q;
    assign crc_cur     = sof ? CrcInit : crc_q;
    assign len_cur     = sof ? 16'd0 : len_q;
    assign err_pre_cur = sof ? 1'b0 : err_pre_q;
    assign txer_cur    = sof ? 1'b0 : txer_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        crc_d     = crc_q;
        len_d     = len_q;
        err_pre_d = err_pre_q;
        txer_d    = txer_q;
        if (clk_enable) begin
            state_d   = cur_state;
            pre_cnt_d = pre_cnt_cur;
            crc_d     = crc_cur;
            len_d     = len_cur;
            err_pre_d = err_pre_cur;
            txer_d    = txer_cur | (gmii_tx_en & gmii_tx_er);
            if (eof) begin
                state_d = StIdle;
            end else if (byte_valid) begin
                unique case (cur_state)
                    StPreamble: begin
                        if (byte_data == 8'h55) begin
                            if (pre_cnt_cur == 4'd7) begin
                                err_pre_d = 1'b1;
                                state_d   = StDrain;
                            end else begin
                                pre_cnt_d = pre_cnt_cur + 4'd1;
                            end
                        end else if ((byte_data == 8'hD5) && (pre_cnt_cur != 4'd0)) begin
                            state_d = StData;
                        end else begin
                            err_pre_d = 1'b1;
                            state_d   = StDrain;
                        end
                    end
                    StData: begin
                        crc_d = crc_byte(crc_cur, byte_data);
                        len_d = (len_cur == 16'hFFFF) ? len_cur : len_cur + 16'd1;
                    end
                    StIdle, StDrain: ;
                endcase
            end
        end
    end

    // Status as it will be published at the end-of-frame sample.
    always_comb begin
        end_pre   = err_pre_q || (state_q == StPreamble);
        end_fcs   = ((state_q == StData) && (crc_q != Residue)) || (mii_select && nib_phase_q);
        end_runt  = (state_q == StData) && (len_q < MinLen);
        end_giant = (state_q == StData) && (len_q > MaxLen);
        end_bad   = end_pre | end_fcs | end_runt | end_giant | txer_q | ifg_err_pend_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt_q      <= 4'd0;
            crc_q          <= CrcInit;
            len_q          <= 16'd0;
            err_pre_q      <= 1'b0;
            txer_q         <= 1'b0;
            nib_phase_q    <= 1'b0;
            nib_lo_q       <= 4'd0;
            idle_phase_q   <= 1'b0;
            first_frame_q  <= 1'b1;
            ifg_cnt_q      <= 8'd0;
            ifg_pend_q     <= 8'd0;
            ifg_err_pend_q <= 1'b0;
            frame_valid    <= 1'b0;
            frame_len      <= 16'd0;
            err_preamble   <= 1'b0;
            err_fcs        <= 1'b0;
            err_runt       <= 1'b0;
            err_giant      <= 1'b0;
            err_tx_er      <= 1'b0;
            err_ifg        <= 1'b0;
            last_ifg       <= 8'd0;
            frame_count    <= 32'd0;
            bad_count      <= 32'd0;
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            crc_q       <= crc_d;
            len_q       <= len_d;
            err_pre_q   <= err_pre_d;
            txer_q      <= txer_d;
            frame_valid <= 1'b0;
            if (clk_enable) begin
                if (!gmii_tx_en) begin
                    nib_phase_q <= 1'b0;
                end else if (mii_select) begin
                    if (!nib_phase_q) begin
                        nib_lo_q <= gmii_txd[3:0];
                    end
                    nib_phase_q <= ~nib_phase_q;
                end
                // An MII idle byte time spans two enabled cycles.
                if ((state_q == StIdle) && !gmii_tx_en) begin
                    if (!mii_select || idle_phase_q) begin
                        ifg_cnt_q <= (ifg_cnt_q == 8'hFF) ? ifg_cnt_q : ifg_cnt_q + 8'd1;
                    end
                    idle_phase_q <= mii_select ? ~idle_phase_q : 1'b0;
                end
                if (sof) begin
                    ifg_pend_q     <= ifg_cnt_q;
                    ifg_err_pend_q <= !first_frame_q && (ifg_cnt_q < ifg_delay);
                end
                if (eof) begin
                    frame_valid   <= 1'b1;
                    frame_len     <= len_q;
                    err_preamble  <= end_pre;
                    err_fcs       <= end_fcs;
                    err_runt      <= end_runt;
                    err_giant     <= end_giant;
                    err_tx_er     <= txer_q;
                    err_ifg       <= ifg_err_pend_q;
                    last_ifg      <= ifg_pend_q;
                    frame_count   <= frame_count + 32'd1;
                    bad_count     <= bad_count + {31'd0, end_bad};
                    first_frame_q <= 1'b0;
                    ifg_cnt_q     <= 8'd0;
                    idle_phase_q  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_gmii_tx_monitor.sv
// Directed bench for gmii_tx_monitor: GMII and MII frames with hand-computed status expectations.
module tb_gmii_tx_monitor;

    logic        clk;
    logic        rst_n;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic        clk_enable;
    logic        mii_select;
    logic [7:0]  ifg_delay;
    logic        frame_valid;
    logic [15:0] frame_len;
    logic        err_preamble, err_fcs, err_runt, err_giant, err_tx_er, err_ifg;
    logic [7:0]  last_ifg;
    logic [31:0] frame_count, bad_count;

    int total = 0;
    int bad   = 0;
    bit mii   = 1'b0;

    gmii_tx_monitor #(.MIN_FRAME_LENGTH(64), .MAX_FRAME_LENGTH(1518)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gmii_txd     (gmii_txd),
        .gmii_tx_en   (gmii_tx_en),
        .gmii_tx_er   (gmii_tx_er),
        .clk_enable   (clk_enable),
        .mii_select   (mii_select),
        .ifg_delay    (ifg_delay),
        .frame_valid  (frame_valid),
        .frame_len    (frame_len),
        .err_preamble (err_preamble),
        .err_fcs      (err_fcs),
        .err_runt     (err_runt),
        .err_giant    (err_giant),
        .err_tx_er    (err_tx_er),
        .err_ifg      (err_ifg),
        .last_ifg     (last_ifg),
        .frame_count  (frame_count),
        .bad_count    (bad_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One enabled sample; in MII mode it is followed by a disabled cycle carrying junk data.
    task automatic samp(input logic [7:0] d, input logic en, input logic er);
        gmii_txd   = d;
        gmii_tx_en = en;
        gmii_tx_er = er;
        clk_enable = 1'b1;
        tick();
        if (mii) begin
            clk_enable = 1'b0;
            gmii_txd   = 8'($urandom);
            tick();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic er);
        if (mii) begin
            samp({4'h0, b[3:0]}, 1'b1, er);
            samp({4'h0, b[7:4]}, 1'b1, er);
        end else begin
            samp(b, 1'b1, er);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < (mii ? 2 * n : n); i++) samp(8'h00, 1'b0, 1'b0);
    endtask

    task automatic eof_sample();
        gmii_txd   = 8'h00;
        gmii_tx_en = 1'b0;
        gmii_tx_er = 1'b0;
        clk_enable = 1'b1;
        tick();
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    // Standard preamble, payload of npay bytes, FCS (optionally corrupted), then the EOF sample.
    task automatic send_frame(input int npay, input bit corrupt, input int er_at);
        logic [7:0]  q[$];
        logic [31:0] crc;
        crc = 32'hFFFF_FFFF;
        for (int i = 0; i < npay; i++) begin
            q.push_back(8'((i * 7 + 3) & 255));
            crc = crc_upd(crc, q[i]);
        end
        crc = ~crc;
        q.push_back(crc[7:0]);
        q.push_back(crc[15:8]);
        q.push_back(crc[23:16]);
        q.push_back(crc[31:24]);
        if (corrupt) q[q.size() - 1] = q[q.size() - 1] ^ 8'h01;
        for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b0);
        send_byte(8'hD5, 1'b0);
        for (int i = 0; i < q.size(); i++) send_byte(q[i], 1'(i == er_at));
        eof_sample();
    endtask

    task automatic report(input string tag, input int len, input bit pre, input bit fcs,
                          input bit runt, input bit giant, input bit txer, input bit ifge,
                          input int ifg, input int fc, input int bc);
        chk({tag, ".valid"}, 32'(frame_valid), 32'd1);
        chk({tag, ".len"}, 32'(frame_len), 32'(len));
        chk({tag, ".pre"}, 32'(err_preamble), 32'(pre));
        chk({tag, ".fcs"}, 32'(err_fcs), 32'(fcs));
        chk({tag, ".runt"}, 32'(err_runt), 32'(runt));
        chk({tag, ".giant"}, 32'(err_giant), 32'(giant));
        chk({tag, ".txer"}, 32'(err_tx_er), 32'(txer));
        chk({tag, ".ifgerr"}, 32'(err_ifg), 32'(ifge));
        chk({tag, ".lastifg"}, 32'(last_ifg), 32'(ifg));
        chk({tag, ".fcount"}, frame_count, 32'(fc));
        chk({tag, ".bcount"}, bad_count, 32'(bc));
        if (mii) begin
            clk_enable = 1'b0;
            tick();
            chk({tag, ".pulse"}, 32'(frame_valid), 32'd0);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        gmii_txd   = 8'h00;
        gmii_tx_en = 1'b0;
        gmii_tx_er = 1'b0;
        clk_enable = 1'b1;
        mii_select = 1'b0;
        ifg_delay  = 8'd12;
        repeat (3) tick();
        chk("rst.valid", 32'(frame_valid), 32'd0);
        chk("rst.len", 32'(frame_len), 32'd0);
        chk("rst.fcount", frame_count, 32'd0);
        chk("rst.bcount", bad_count, 32'd0);
        chk("rst.flags", 32'({err_preamble, err_fcs, err_runt, err_giant, err_tx_er, err_ifg}),
            32'd0);
        rst_n = 1'b1;
        idle(3);

        send_frame(60, 1'b0, -1);
        report("good", 64, 0, 0, 0, 0, 0, 0, 3, 1, 0);
        idle(1);
        chk("good.pulse", 32'(frame_valid), 32'd0);
        idle(11);

        send_frame(60, 1'b1, -1);
        report("badfcs", 64, 0, 1, 0, 0, 0, 0, 12, 2, 1);
        idle(8);
        send_frame(60, 1'b0, -1);
        report("ifg8", 64, 0, 0, 0, 0, 0, 1, 8, 3, 2);
        idle(12);
        send_frame(60, 1'b0, -1);
        report("ifg12", 64, 0, 0, 0, 0, 0, 0, 12, 4, 2);
        idle(12);

        send_frame(46, 1'b0, -1);
        report("runt", 50, 0, 0, 1, 0, 0, 0, 12, 5, 3);
        idle(12);
        send_frame(1515, 1'b0, -1);
        report("giant", 1519, 0, 0, 0, 1, 0, 0, 12, 6, 4);
        idle(12);

        send_byte(8'h55, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h5D, 1'b0);
        send_byte(8'hD5, 1'b0);
        for (int i = 0; i < 10; i++) send_byte(8'hAA, 1'b0);
        eof_sample();
        report("pre", 0, 1, 0, 0, 0, 0, 0, 12, 7, 5);
        idle(12);

        mii        = 1'b1;
        mii_select = 1'b1;
        send_frame(60, 1'b0, -1);
        report("mii", 64, 0, 0, 0, 0, 0, 0, 12, 8, 5);
        idle(12);
        send_frame(60, 1'b0, 25);
        report("miitxer", 64, 0, 0, 0, 0, 1, 0, 12, 9, 6);
        idle(12);

        for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b0);
        send_byte(8'hD5, 1'b0);
        for (int i = 0; i < 20; i++) send_byte(8'(i), 1'b0);
        rst_n      = 1'b0;
        gmii_tx_en = 1'b0;
        clk_enable = 1'b1;
        tick();
        tick();
        chk("midrst.valid", 32'(frame_valid), 32'd0);
        chk("midrst.fcount", frame_count, 32'd0);
        chk("midrst.bcount", bad_count, 32'd0);
        rst_n = 1'b1;
        idle(4);
        chk("midrst.novalid", 32'(frame_valid), 32'd0);
        chk("midrst.fcount2", frame_count, 32'd0);
        send_frame(60, 1'b0, -1);
        report("postrst", 64, 0, 0, 0, 0, 0, 0, 4, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gmii_tx_monitor.md
Name: gmii_tx_monitor

Overview:
- Passive GMII/MII checker sitting on the PHY side of the MAC transmit path; observes gmii_txd/gmii_tx_en/gmii_tx_er as driven by the MAC.
- Per frame it validates preamble/SFD, FCS, length bounds, inter-frame gap and tx_er, then reports a per-frame status and running counters.
- Used in-system on the Ethernet link for field diagnostics and in benches as the transmit-side scoreboard.

Parameters:
- MIN_FRAME_LENGTH, 64, minimum bytes after SFD including FCS; shorter frames are flagged runt.
- MAX_FRAME_LENGTH, 1518, maximum bytes after SFD including FCS; longer frames are flagged giant.

Ports:
- clk  in  1  transmit clock
- rst_n  in  1  synchronous active-low reset
- gmii_txd  in  8  transmit data from MAC
- gmii_tx_en  in  1  transmit enable from MAC
- gmii_tx_er  in  1  transmit error from MAC
- clk_enable  in  1  sample qualifier; inputs are ignored on cycles where it is low
- mii_select  in  1  1 = MII nibble mode (gmii_txd[3:0], low nibble first), 0 = GMII byte mode
- ifg_delay  in  8  required minimum IFG in byte times
- frame_valid  out  1  one-cycle pulse: status outputs updated
- frame_len  out  16  bytes after SFD including FCS, saturates at 16'hFFFF
- err_preamble  out  1  bad or missing preamble/SFD
- err_fcs  out  1  FCS residue mismatch
- err_runt  out  1  frame_len < MIN_FRAME_LENGTH
- err_giant  out  1  frame_len > MAX_FRAME_LENGTH
- err_tx_er  out  1  gmii_tx_er seen while gmii_tx_en was high
- err_ifg  out  1  preceding gap < ifg_delay
- last_ifg  out  8  preceding gap in byte times, saturates at 255
- frame_count  out  32  frames seen, wraps
- bad_count  out  32  frames with any error flag set, wraps

Behaviour:
- Reset (rst_n low at a clk edge): all outputs 0, FSM in IDLE, IFG counter 0, first_frame flag set.
- Byte assembly: GMII gives one byte per enabled cycle. In MII mode a byte completes on every second enabled cycle with gmii_tx_en high: first nibble goes to [3:0], second to [7:4]. The nibble phase resets whenever gmii_tx_en is low.
- A tx_en falling edge on an odd nibble sets err_fcs.
- FSM states: IDLE, PREAMBLE, DATA, DRAIN.
  - IDLE: counts enabled byte times with tx_en low into the IFG counter. On the first byte with tx_en high, latch last_ifg and set err_ifg = (!first_frame && ifg < ifg_delay), then enter PREAMBLE.
  - PREAMBLE: byte 0x55 increments the preamble count. Byte 0xD5 with count 1..7 goes to DATA. Any other byte, a count above 7, or a 0xD5 with count 0 sets err_preamble and goes to DRAIN.
  - DATA: each byte updates the CRC (reflected CRC-32, polynomial 0xEDB88320, init 0xFFFFFFFF) and increments frame_len (saturating).
  - On tx_en low, end of frame. err_fcs = (crc != 0xDEBB20E3); evaluate runt and giant. A frame ending in PREAMBLE sets err_preamble.
  - DRAIN: wait for tx_en low, then end of frame.
- End of frame:
  - One cycle after the enabled sample where tx_en is low, frame_valid pulses and all status outputs update; they hold until the next end of frame.
  - frame_count increments; bad_count increments if any err_* is set.
  - Clear first_frame, zero the IFG counter, return to IDLE.
- gmii_tx_er high with tx_en high in any state latches err_tx_er for the current frame.
- When clk_enable is low: no state change, no IFG count, frame_valid stays 0.
- A frame still in progress at reset is discarded and never reported.
- Counter wrap: 0xFFFFFFFF + 1 gives 0, with no flag.

Test Plan:
- Reset, then in GMII mode send 7×0x55, 0xD5, a 60-byte payload and a correct FCS -> frame_valid pulse, frame_len=64, all err_*=0, frame_count=1, bad_count=0, err_ifg=0.
- Same frame with the last FCS byte XOR 0x01 -> err_fcs=1, bad_count=1.
- Two good frames with 8 idle byte times between them and ifg_delay=12 -> second report has last_ifg=8, err_ifg=1. Repeat with a 12-byte gap -> err_ifg=0.
- 46-byte frame with correct FCS (frame_len=50) -> err_runt=1. 1519-byte frame -> err_giant=1.
- Preamble 0x55,0x55,0x5D,0xD5 -> err_preamble=1, no FCS evaluation.
- MII mode with clk_enable toggling every other cycle, good 64-byte frame -> frame_len=64, no errors. tx_er pulsed mid-frame -> err_tx_er=1. rst_n low mid-frame -> counters 0, no frame_valid.
